// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_pkg
// Brief    : Shared CNN datapath constants, pooling phase type and the
//            signed max helper used by the ReLU and max-pool stages.
// Revision : 1.0 - initial release
// ============================================================================
package cnn_pkg;

  localparam int IMG_WIDTH      = 28;
  localparam int CONV_OUT_WIDTH = 26;
  localparam int POOL_OUT_WIDTH = 13;
  localparam int ACC_WIDTH      = 32;

  // Which half of a 2x2 window the current input row feeds.
  typedef enum logic [1:0] {
    TOP    = 2'd0,
    BOTTOM = 2'd1,
    DROP   = 2'd2
  } pool_phase_e;

  // Signed maximum at full accumulator width.
  function automatic logic signed [ACC_WIDTH-1:0] max2(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_row_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pool_row_buffer
// Brief    : Half-row register array holding the horizontal maxima of the
//            top row of each 2x2 window. One write port, one combinational
//            read port. Not reset: every entry is written before it is read.
// Revision : 1.0 - initial release
// ============================================================================
module pool_row_buffer #(
  parameter int DEPTH      = 13,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 4
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic [ADDR_W-1:0]            waddr_i,
  input  logic signed [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]            raddr_i,
  output logic signed [DATA_WIDTH-1:0] rdata_o
);

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  // Store the top-row pair maximum for the column pair being completed.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule
`default_nettype wire

// File: rtl/max_pool_stream.sv
`default_nettype none
// ============================================================================
// Module   : max_pool_stream
// Brief    : Streaming 2x2 / stride-2 signed max-pool over a raster-ordered
//            feature map with valid/ready on both sides. A half-row buffer
//            carries the top-row maxima down to the bottom row of each window.
//            DATA_WIDTH must not exceed cnn_pkg::ACC_WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module max_pool_stream
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IN_WIDTH   = 26,
  parameter int IN_HEIGHT  = 26
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic signed [DATA_WIDTH-1:0] in_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic signed [DATA_WIDTH-1:0] out_data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         frame_done_o
);

  localparam int COL_W     = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
  localparam int ROW_W     = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int BUF_DEPTH = (IN_WIDTH + 1) / 2;
  localparam int ADDR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IN_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IN_HEIGHT - 1);
  localparam bit ODD_W = (IN_WIDTH  % 2) == 1;
  localparam bit ODD_H = (IN_HEIGHT % 2) == 1;

  logic [COL_W-1:0]             col;
  logic [ROW_W-1:0]             row;
  pool_phase_e                  phase;
  logic signed [DATA_WIDTH-1:0] hmax;
  logic signed [DATA_WIDTH-1:0] out_data_q;
  logic                         out_valid_q;
  logic                         frame_done_q;

  logic                         accept;
  logic                         col_last;
  logic                         row_last;
  logic                         trail_col;
  logic [ROW_W-1:0]             next_row;
  logic                         rb_we;
  logic [ADDR_W-1:0]            rb_addr;
  logic signed [DATA_WIDTH-1:0] rb_wdata;
  logic signed [DATA_WIDTH-1:0] rb_rdata;
  logic signed [DATA_WIDTH-1:0] window_max;

  // Signed max at sample width, routed through the shared helper.
  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return DATA_WIDTH'(max2(ACC_WIDTH'(a), ACC_WIDTH'(b)));
  endfunction

  // Phase a row belongs to: odd rows close windows, an unpaired last row is dropped.
  function automatic pool_phase_e phase_for(input logic [ROW_W-1:0] r);
    if (r[0]) begin
      return BOTTOM;
    end else if (ODD_H && (r == LAST_ROW)) begin
      return DROP;
    end else begin
      return TOP;
    end
  endfunction

  // Single output register: accept whenever it is empty or draining this cycle.
  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign col_last   = (col == LAST_COL);
  assign row_last   = (row == LAST_ROW);
  assign trail_col  = ODD_W && col_last;
  assign next_row   = row_last ? '0 : row + ROW_W'(1);

  assign rb_addr    = ADDR_W'(col >> 1);
  assign rb_wdata   = smax(hmax, in_data_i);
  assign rb_we      = accept && !clear_i && (phase == TOP) && col[0];
  assign window_max = smax(smax(rb_rdata, hmax), in_data_i);

  pool_row_buffer #(
    .DEPTH      (BUF_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_row_buffer (
    .clk_i   (clk_i),
    .we_i    (rb_we),
    .waddr_i (rb_addr),
    .wdata_i (rb_wdata),
    .raddr_i (rb_addr),
    .rdata_o (rb_rdata)
  );

  // Raster counters, phase tracking, horizontal max and the output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col          <= '0;
      row          <= '0;
      phase        <= TOP;
      hmax         <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (clear_i) begin
      col          <= '0;
      row          <= '0;
      phase        <= TOP;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= accept && col_last && row_last;
      if (out_valid_q && out_ready_i) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        if (col_last) begin
          col   <= '0;
          row   <= next_row;
          phase <= phase_for(next_row);
        end else begin
          col <= col + COL_W'(1);
        end
        // Trailing odd column and dropped last row are counted but ignored.
        if (!trail_col && (phase != DROP)) begin
          if (!col[0]) begin
            hmax <= in_data_i;
          end else if (phase == BOTTOM) begin
            out_data_q  <= window_max;
            out_valid_q <= 1'b1;
          end
        end
      end
    end
  end

  assign out_data_o   = out_data_q;
  assign out_valid_o  = out_valid_q;
  assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_max_pool_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_max_pool_stream
// Brief    : Self-checking bench for max_pool_stream with three instances
//            (4x4, 5x5, 26x26). A raster image model predicts every pooled
//            output and frame_done pulse; literal expectations pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_max_pool_stream;

  localparam int DW = 32;
  localparam int N  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 clear      [N];
  logic signed [DW-1:0] in_data    [N];
  logic                 in_valid   [N];
  logic                 in_ready   [N];
  logic signed [DW-1:0] out_data   [N];
  logic                 out_valid  [N];
  logic                 out_ready  [N];
  logic                 frame_done [N];
  int                   rmode      [N];

  logic signed [DW-1:0] cap   [N][0:1023];
  int                   ncap  [N] = '{0, 0, 0};
  int                   ndone [N] = '{0, 0, 0};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic signed [DW-1:0] mx(input logic signed [DW-1:0] a,
                                              input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = (g == 0) ? 4 : (g == 1) ? 5 : 26;
    localparam int H = W;

    max_pool_stream #(
      .DATA_WIDTH (DW),
      .IN_WIDTH   (W),
      .IN_HEIGHT  (H)
    ) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .clear_i      (clear[g]),
      .in_data_i    (in_data[g]),
      .in_valid_i   (in_valid[g]),
      .in_ready_o   (in_ready[g]),
      .out_data_o   (out_data[g]),
      .out_valid_o  (out_valid[g]),
      .out_ready_i  (out_ready[g]),
      .frame_done_o (frame_done[g])
    );

    // Downstream acceptance pattern per instance: 0 always, 1 never, 2 random.
    always @(posedge clk) begin
      #1;
      case (rmode[g])
        0:       out_ready[g] = 1'b1;
        1:       out_ready[g] = 1'b0;
        default: out_ready[g] = 1'($urandom_range(0, 1));
      endcase
    end

    logic signed [DW-1:0] img [W*H];
    logic signed [DW-1:0] q [$];
    logic signed [DW-1:0] prev_data;
    logic signed [DW-1:0] e;
    int pos = 0;
    bit exp_done = 1'b0;
    bit prev_stall = 1'b0;

    // Reference model and compare: image positions, window maxima, frame pulses.
    always @(negedge clk) begin
      if (!rst_n) begin
        pos = 0;
        q.delete();
        exp_done = 1'b0;
        prev_stall = 1'b0;
      end else begin
        chk("frame_done", frame_done[g], exp_done);
        if (frame_done[g]) ndone[g]++;
        chk("out_valid", out_valid[g], q.size() != 0);
        if (prev_stall) chk("stall_hold", out_data[g], prev_data);
        if (out_valid[g] && !out_ready[g]) chk("backpressure", in_ready[g], 0);
        if (out_valid[g] && out_ready[g] && q.size() != 0) begin
          e = q.pop_front();
          chk("out_data", out_data[g], e);
          if (ncap[g] < 1024) cap[g][ncap[g]] = out_data[g];
          ncap[g]++;
        end
        prev_stall = out_valid[g] && !out_ready[g] && !clear[g];
        prev_data  = out_data[g];
        exp_done   = 1'b0;
        if (clear[g]) begin
          pos = 0;
          q.delete();
        end else if (in_valid[g] && in_ready[g]) begin
          int r, c;
          r = pos / W;
          c = pos % W;
          img[pos] = in_data[g];
          if ((r % 2 == 1) && (c % 2 == 1))
            q.push_back(mx(mx(img[(r-1)*W + c-1], img[(r-1)*W + c]),
                           mx(img[r*W + c-1], in_data[g])));
          if (pos == W*H - 1) exp_done = 1'b1;
          pos = (pos + 1) % (W*H);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic signed [DW-1:0] v);
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    in_valid[k] = 1'b1;
    in_data[k]  = v;
    while (!acc && t < 2000) begin
      @(negedge clk);
      acc = in_ready[k];
      step();
      t++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_out(input int k, input int target);
    int t;
    t = 0;
    while (ncap[k] < target && t < 5000) begin
      step();
      t++;
    end
    if (ncap[k] < target) chk("drain_timeout", ncap[k], target);
    repeat (3) step();
  endtask

  task automatic pin(input int k, input int base, input string nm,
                     input int e[8], input int n);
    chk({nm, "_count"}, ncap[k] - base, n);
    for (int i = 0; i < n; i++)
      if (base + i < ncap[k] && base + i < 1024) chk(nm, cap[k][base+i], e[i]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, dbase;
    time t0;
    for (int k = 0; k < N; k++) begin
      clear[k] = 1'b0; in_valid[k] = 1'b0; in_data[k] = '0; rmode[k] = 0;
    end
    #12;
    for (int k = 0; k < N; k++) begin
      chk("rst_out_valid", out_valid[k], 0);
      chk("rst_out_data", out_data[k], 0);
      chk("rst_frame_done", frame_done[k], 0);
    end
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // 4x4 ascending ramp.
    base = ncap[0]; dbase = ndone[0];
    for (int i = 0; i < 16; i++) send(0, DW'(i));
    wait_out(0, base + 4);
    pin(0, base, "ramp4", '{5, 7, 13, 15, 0, 0, 0, 0}, 4);
    chk("ramp4_done", ndone[0] - dbase, 1);

    // 4x4 all negative.
    base = ncap[0];
    for (int i = 0; i < 16; i++) send(0, DW'(i - 16));
    wait_out(0, base + 4);
    pin(0, base, "neg4", '{-11, -9, -3, -1, 0, 0, 0, 0}, 4);

    // 5x5 with trailing column and row.
    base = ncap[1]; dbase = ndone[1];
    for (int i = 0; i < 25; i++) send(1, DW'(i));
    wait_out(1, base + 4);
    pin(1, base, "odd5", '{6, 8, 16, 18, 0, 0, 0, 0}, 4);
    chk("odd5_done", ndone[1] - dbase, 1);

    // Two back-to-back 4x4 frames.
    base = ncap[0]; dbase = ndone[0];
    t0 = $time;
    for (int i = 0; i < 16; i++) send(0, DW'(i));
    for (int i = 0; i < 16; i++) send(0, DW'(i + 100));
    chk("b2b_cycles", ($time - t0) / 10, 32);
    wait_out(0, base + 8);
    pin(0, base, "b2b", '{5, 7, 13, 15, 105, 107, 113, 115}, 8);
    chk("b2b_done", ndone[0] - dbase, 2);

    // Clear after six inputs while the first window result is stalled.
    rmode[0] = 1;
    repeat (2) step();
    base = ncap[0];
    for (int i = 0; i < 6; i++) send(0, DW'(50 + i));
    clear[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 99;
    step();
    clear[0] = 1'b0; in_valid[0] = 1'b0;
    rmode[0] = 0;
    repeat (2) step();
    chk("clear_dropped", ncap[0] - base, 0);
    for (int i = 0; i < 16; i++) send(0, DW'(i));
    wait_out(0, base + 4);
    pin(0, base, "after_clear", '{5, 7, 13, 15, 0, 0, 0, 0}, 4);

    // 26x26 random data with random stalls and input gaps.
    rmode[2] = 2;
    base = ncap[2]; dbase = ndone[2];
    for (int i = 0; i < 26*26; i++) begin
      send(2, DW'($urandom));
      if ($urandom_range(0, 3) == 0) step();
    end
    wait_out(2, base + 169);
    chk("rand26_count", ncap[2] - base, 169);
    chk("rand26_done", ndone[2] - dbase, 1);
    rmode[2] = 0;
    repeat (3) step();

    // Asynchronous reset mid-frame with a stalled result pending.
    rmode[0] = 1;
    repeat (2) step();
    for (int i = 0; i < 6; i++) send(0, DW'(20 + i));
    chk("pre_rst_valid", out_valid[0], 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid[0], 0);
    chk("arst_out_data", out_data[0], 0);
    chk("arst_frame_done", frame_done[0], 0);
    chk("arst_in_ready", in_ready[0], 1);
    step();
    rst_n = 1'b1;
    rmode[0] = 0;
    repeat (2) step();
    base = ncap[0];
    for (int i = 0; i < 16; i++) send(0, DW'(i));
    wait_out(0, base + 4);
    pin(0, base, "after_rst", '{5, 7, 13, 15, 0, 0, 0, 0}, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
